// File: rtl/sdram_sched_pkg.sv
// Shared encodings and address widths for the SDRAM burst scheduler.
package sdram_sched_pkg;

  localparam int unsigned ROW_W  = 13;
  localparam int unsigned COL_W  = 9;
  localparam int unsigned BANK_W = 2;

  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_REF  = 2'b01,
    CMD_WR   = 2'b10,
    CMD_RD   = 2'b11
  } cmd_type_e;

  typedef enum logic [1:0] {
    StIdle,
    StArb,
    StReq,
    StWait
  } sched_state_e;

endpackage

// File: rtl/sdram_ref_timer.sv
// Refresh interval timer: raises ref_pend once per period and flags a period that
// elapses while the previous refresh is still outstanding.
module sdram_ref_timer
  import sdram_sched_pkg::*;
#(
  parameter int unsigned REF_PERIOD = 780
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic ref_pend,
  output logic ref_overrun
);

  localparam int unsigned CntW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REF_PERIOD - 1);

  logic [CntW-1:0] cnt_q;
  logic            wrap;

  assign wrap = en && (cnt_q == CntMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      ref_pend    <= 1'b0;
      ref_overrun <= 1'b0;
    end else begin
      if (!en || wrap) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      // A new period wins over a same-cycle clear so that request is not lost.
      if (wrap) begin
        ref_pend <= 1'b1;
      end else if (clr) begin
        ref_pend <= 1'b0;
      end
      if (wrap && ref_pend && !clr) begin
        ref_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_burst_sched.sv
// Burst scheduler: arbitrates refresh / write / read bursts towards the SDRAM command engine
// and walks ping-pong frame buffers in banks 0 and 1.
module sdram_burst_sched
  import sdram_sched_pkg::*;
#(
  parameter int unsigned REF_PERIOD = 780,
  parameter int unsigned BURST_LEN  = 256,
  parameter int unsigned FRAME_ROWS = 1024,
  parameter int unsigned FIFO_DEPTH = 1024,
  parameter int unsigned R_THRESH   = FIFO_DEPTH - BURST_LEN
) (
  input  logic                          sysclk_100M,
  input  logic                          rst_n,
  input  logic                          init_done,
  input  logic [$clog2(FIFO_DEPTH)-1:0] w_data_count,
  input  logic [$clog2(FIFO_DEPTH)-1:0] r_data_count,
  output logic                          cmd_req,
  output logic [1:0]                    cmd_type,
  output logic [BANK_W-1:0]             cmd_bank,
  output logic [ROW_W-1:0]              cmd_row,
  output logic [COL_W-1:0]              cmd_col,
  input  logic                          cmd_ack,
  input  logic                          cmd_done,
  output logic                          write_end,
  output logic                          ref_overrun
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH);
  localparam logic [CntW:0]       BurstLenC = (CntW + 1)'(BURST_LEN);
  localparam logic [CntW:0]       RThreshC  = (CntW + 1)'(R_THRESH);
  localparam logic [COL_W-1:0]    ColStep   = COL_W'(BURST_LEN);
  localparam logic [COL_W-1:0]    ColLast   = COL_W'(512 - BURST_LEN);
  localparam logic [ROW_W-1:0]    RowLast   = ROW_W'(FRAME_ROWS - 1);

  sched_state_e     state_q;
  logic             wr_buf_q, rd_buf_q, last_done_q, last_wr_q;
  logic [ROW_W-1:0] wr_row_q, rd_row_q;
  logic [COL_W-1:0] wr_col_q, rd_col_q;

  logic      ref_pend, ref_clr;
  logic      wr_elig, rd_elig, rd_bank_sel, ack_fire;
  cmd_type_e pick;

  always_comb begin
    wr_elig     = {1'b0, w_data_count} >= BurstLenC;
    rd_elig     = write_end && ({1'b0, r_data_count} <= RThreshC);
    // A read frame always starts on the most recently completed write frame.
    rd_bank_sel = (rd_row_q == '0 && rd_col_q == '0) ? last_done_q : rd_buf_q;
    ack_fire    = (state_q == StReq) && cmd_ack;
    ref_clr     = ack_fire && (cmd_type == CMD_REF);
    pick        = CMD_NONE;
    if (ref_pend) begin
      pick = CMD_REF;
    end else if (wr_elig && rd_elig) begin
      pick = last_wr_q ? CMD_RD : CMD_WR;
    end else if (wr_elig) begin
      pick = CMD_WR;
    end else if (rd_elig) begin
      pick = CMD_RD;
    end
  end

  sdram_ref_timer #(
    .REF_PERIOD(REF_PERIOD)
  ) u_ref_timer (
    .clk        (sysclk_100M),
    .rst_n      (rst_n),
    .en         (init_done),
    .clr        (ref_clr),
    .ref_pend   (ref_pend),
    .ref_overrun(ref_overrun)
  );

  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cmd_req     <= 1'b0;
      cmd_type    <= CMD_NONE;
      cmd_bank    <= '0;
      cmd_row     <= '0;
      cmd_col     <= '0;
      write_end   <= 1'b0;
      wr_buf_q    <= 1'b0;
      rd_buf_q    <= 1'b0;
      last_done_q <= 1'b0;
      last_wr_q   <= 1'b0;
      wr_row_q    <= '0;
      wr_col_q    <= '0;
      rd_row_q    <= '0;
      rd_col_q    <= '0;
    end else if (!init_done) begin
      state_q  <= StIdle;
      cmd_req  <= 1'b0;
      cmd_type <= CMD_NONE;
    end else begin
      unique case (state_q)
        StIdle: state_q <= StArb;
        StArb: begin
          if (pick != CMD_NONE) begin
            state_q  <= StReq;
            cmd_req  <= 1'b1;
            cmd_type <= pick;
            unique case (pick)
              CMD_WR: begin
                cmd_bank  <= {{(BANK_W - 1){1'b0}}, wr_buf_q};
                cmd_row   <= wr_row_q;
                cmd_col   <= wr_col_q;
                last_wr_q <= 1'b1;
              end
              CMD_RD: begin
                cmd_bank  <= {{(BANK_W - 1){1'b0}}, rd_bank_sel};
                cmd_row   <= rd_row_q;
                cmd_col   <= rd_col_q;
                rd_buf_q  <= rd_bank_sel;
                last_wr_q <= 1'b0;
              end
              default: begin
                cmd_bank <= '0;
                cmd_row  <= '0;
                cmd_col  <= '0;
              end
            endcase
          end
        end
        StReq: begin
          if (cmd_ack) begin
            cmd_req  <= 1'b0;
            cmd_type <= CMD_NONE;
            state_q  <= cmd_done ? StArb : StWait;
            if (cmd_type == CMD_WR) begin
              if (wr_col_q == ColLast) begin
                wr_col_q <= '0;
                if (wr_row_q == RowLast) begin
                  wr_row_q    <= '0;
                  last_done_q <= wr_buf_q;
                  wr_buf_q    <= ~wr_buf_q;
                  write_end   <= 1'b1;
                end else begin
                  wr_row_q <= wr_row_q + 1'b1;
                end
              end else begin
                wr_col_q <= wr_col_q + ColStep;
              end
            end else if (cmd_type == CMD_RD) begin
              if (rd_col_q == ColLast) begin
                rd_col_q <= '0;
                rd_row_q <= (rd_row_q == RowLast) ? '0 : rd_row_q + 1'b1;
              end else begin
                rd_col_q <= rd_col_q + ColStep;
              end
            end
          end
        end
        StWait: if (cmd_done) state_q <= StArb;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Directed bench for sdram_burst_sched with a small behavioural command engine.
module tb_sdram_burst_sched;

  logic       sysclk_100M = 1'b0;
  logic       rst_n, init_done, cmd_ack, cmd_done;
  logic [9:0] w_data_count, r_data_count;
  logic       cmd_req, write_end, ref_overrun;
  logic [1:0] cmd_type, cmd_bank;
  logic [12:0] cmd_row;
  logic [8:0] cmd_col;

  always #5 sysclk_100M = ~sysclk_100M;

  sdram_burst_sched dut (
    .sysclk_100M (sysclk_100M),
    .rst_n       (rst_n),
    .init_done   (init_done),
    .w_data_count(w_data_count),
    .r_data_count(r_data_count),
    .cmd_req     (cmd_req),
    .cmd_type    (cmd_type),
    .cmd_bank    (cmd_bank),
    .cmd_row     (cmd_row),
    .cmd_col     (cmd_col),
    .cmd_ack     (cmd_ack),
    .cmd_done    (cmd_done),
    .write_end   (write_end),
    .ref_overrun (ref_overrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Engine model: acks ack_dly cycles after cmd_req is seen, done done_dly cycles after ack.
  int   ack_dly = 0, done_dly = 0, cyc = 0, wcnt = 0, dcnt = -1, rise = 0;
  bit   hold_wr = 1'b0, in_req = 1'b0;
  logic [1:0]  lt[$];
  logic [1:0]  lb[$];
  logic [12:0] lr[$];
  logic [8:0]  lc[$];
  logic        lwe[$];
  int          lrise[$];

  initial begin
    cmd_ack  = 1'b0;
    cmd_done = 1'b0;
    forever begin
      @(posedge sysclk_100M);
      #1;
      cyc++;
      cmd_ack  = 1'b0;
      cmd_done = 1'b0;
      if (!rst_n) begin
        wcnt   = 0;
        dcnt   = -1;
        in_req = 1'b0;
      end else begin
        if (dcnt == 0) begin
          cmd_done = 1'b1;
          dcnt     = -1;
        end else if (dcnt > 0) begin
          dcnt--;
        end
        if (cmd_req) begin
          if (!in_req) begin
            in_req = 1'b1;
            rise   = cyc;
            wcnt   = 0;
          end
          if (!(hold_wr && cmd_type == 2'b10) && wcnt >= ack_dly) begin
            cmd_ack = 1'b1;
            lt.push_back(cmd_type);
            lb.push_back(cmd_bank);
            lr.push_back(cmd_row);
            lc.push_back(cmd_col);
            lwe.push_back(write_end);
            lrise.push_back(rise);
            if (done_dly == 0) cmd_done = 1'b1;
            else dcnt = done_dly - 1;
            in_req = 1'b0;
          end else begin
            wcnt++;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sysclk_100M);
      #2;
    end
  endtask

  task automatic clear_log();
    lt.delete(); lb.delete(); lr.delete(); lc.delete(); lwe.delete(); lrise.delete();
  endtask

  function automatic int count_type(input logic [1:0] t);
    int n = 0;
    foreach (lt[i]) if (lt[i] == t) n++;
    return n;
  endfunction

  task automatic check_outputs_zero(input string pfx);
    check_eq({pfx, "_req"}, cmd_req, 0);
    check_eq({pfx, "_type"}, cmd_type, 0);
    check_eq({pfx, "_bank"}, cmd_bank, 0);
    check_eq({pfx, "_row"}, cmd_row, 0);
    check_eq({pfx, "_col"}, cmd_col, 0);
    check_eq({pfx, "_write_end"}, write_end, 0);
    check_eq({pfx, "_overrun"}, ref_overrun, 0);
  endtask

  initial begin
    int c0, nbad, k, nrd, nwr_bank_bad, alt_bad, rd_bad;
    logic [1:0] prev;
    logic [1:0] cap_bank;
    logic [12:0] cap_row;
    logic [8:0] cap_col;
    bit found;

    rst_n = 1'b0; init_done = 1'b0; w_data_count = '0; r_data_count = '0;
    tick(3);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // init_done low: nothing may be requested
    nbad = 0;
    repeat (2000) begin
      tick(1);
      if (cmd_req || cmd_type != 2'b00) nbad++;
    end
    check_eq("idle_no_req", nbad, 0);
    check_eq("idle_no_cmds", lt.size(), 0);

    // refresh only; first request lands 781 edges after init_done rises
    ack_dly   = 2;
    init_done = 1'b1;
    c0        = cyc;
    tick(2400);
    check_eq("ref_count", lt.size(), 3);
    check_eq("ref_nonref", lt.size() - count_type(2'b01), 0);
    if (lt.size() >= 3) begin
      check_eq("ref_first_lat", lrise[0] - c0, 781);
      check_eq("ref_interval1", lrise[1] - lrise[0], 780);
      check_eq("ref_interval2", lrise[2] - lrise[1], 780);
      check_eq("ref_bank", lb[0], 0);
    end

    // one full frame of writes plus one
    clear_log();
    ack_dly = 0;
    r_data_count = 10'd1023;
    w_data_count = 10'd300;
    k = 0;
    while (count_type(2'b10) < 2050 && k < 10000) begin
      tick(1);
      k++;
    end
    check_eq("wr_frame_reached", count_type(2'b10) >= 2050, 1);
    w_data_count = '0;
    tick(10);
    k = 0; nbad = 0;
    foreach (lt[i]) begin
      if (lt[i] == 2'b10) begin
        if (lb[i] != 2'((k / 2048) % 2) || lr[i] != 13'((k / 2) % 1024) ||
            lc[i] != 9'((k % 2) * 256)) nbad++;
        if (k == 1) check_eq("wr1_col", lc[i], 256);
        if (k == 2) check_eq("wr2_row", lr[i], 1);
        if (k == 2) check_eq("wr2_col", lc[i], 0);
        if (k == 2047) check_eq("wr2047_write_end", lwe[i], 0);
        if (k == 2048) check_eq("wr2048_write_end", lwe[i], 1);
        if (k == 2048) check_eq("wr2048_bank", lb[i], 1);
        if (k == 2048) check_eq("wr2048_row", lr[i], 0);
        k++;
      end
    end
    check_eq("wr_addr_seq", nbad, 0);
    check_eq("wr_refresh_interleaved", count_type(2'b01) > 0, 1);
    check_eq("write_end_set", write_end, 1);

    // write/read alternation with reads on the finished frame
    clear_log();
    w_data_count = 10'd300;
    r_data_count = '0;
    tick(200);
    prev = 2'b00; nrd = 0; nwr_bank_bad = 0; alt_bad = 0; rd_bad = 0;
    foreach (lt[i]) begin
      if (lt[i] == 2'b10 || lt[i] == 2'b11) begin
        if (prev == lt[i]) alt_bad++;
        prev = lt[i];
      end
      if (lt[i] == 2'b10 && lb[i] != 2'd1) nwr_bank_bad++;
      if (lt[i] == 2'b11) begin
        if (lb[i] != 2'd0 || lr[i] != 13'(nrd / 2) || lc[i] != 9'((nrd % 2) * 256)) rd_bad++;
        nrd++;
      end
    end
    check_eq("alt_read_count", nrd >= 20, 1);
    check_eq("alt_strict", alt_bad, 0);
    check_eq("alt_rd_addr", rd_bad, 0);
    check_eq("alt_wr_bank", nwr_bank_bad, 0);

    // stalled write request must hold its address while refreshes overrun
    r_data_count = 10'd1023;
    hold_wr = 1'b1;
    check_eq("overrun_before", ref_overrun, 0);
    found = 1'b0;
    k = 0;
    while (!found && k < 100) begin
      tick(1);
      k++;
      if (cmd_req && cmd_type == 2'b10) found = 1'b1;
    end
    check_eq("stall_wr_req_seen", found, 1);
    cap_bank = cmd_bank; cap_row = cmd_row; cap_col = cmd_col;
    nbad = 0;
    repeat (1600) begin
      tick(1);
      if (!cmd_req || cmd_type != 2'b10 || cmd_bank != cap_bank || cmd_row != cap_row ||
          cmd_col != cap_col) nbad++;
    end
    check_eq("stall_stable", nbad, 0);
    check_eq("stall_bank", cap_bank, 1);
    check_eq("overrun_set", ref_overrun, 1);
    hold_wr = 1'b0;
    tick(20);

    // asynchronous reset while the DUT waits for cmd_done
    done_dly = 5;
    found = 1'b0;
    k = 0;
    while (!found && k < 200) begin
      tick(1);
      k++;
      if (dcnt > 0 && !cmd_req) found = 1'b1;
    end
    check_eq("wait_state_seen", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    @(negedge sysclk_100M);
    clear_log();
    done_dly = 0;
    r_data_count = '0;
    w_data_count = 10'd300;
    rst_n = 1'b1;
    k = 0;
    while (lt.size() < 1 && k < 50) begin
      tick(1);
      k++;
    end
    check_eq("post_rst_cmd_seen", lt.size() >= 1, 1);
    if (lt.size() >= 1) begin
      check_eq("post_rst_type", lt[0], 2);
      check_eq("post_rst_bank", lb[0], 0);
      check_eq("post_rst_row", lr[0], 0);
      check_eq("post_rst_col", lc[0], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
